// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registered ALU-operation select stage with an LDM/STM
// block-transfer sequencer. A normal cycle registers the operation picked by
// alu_op_mux; a block sequence emits one ADD/SUB address step per set bit of
// the register list, lowest register first, followed by a one-cycle done pulse.
// A stall freezes every register, outputs included.

module alu_op_sequencer #(
    parameter int              OP_W   = 4,
    parameter int              LIST_W = 16,
    parameter int              IDX_W  = 4,
    parameter logic [OP_W-1:0] OP_ADD = OP_W'(4),
    parameter logic [OP_W-1:0] OP_SUB = OP_W'(2),
    parameter logic [OP_W-1:0] OP_MOV = OP_W'(13)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        alu_op_mux,
    input  logic [OP_W-1:0]   ir_op,
    input  logic [OP_W-1:0]   cs_op,
    input  logic              u,
    input  logic              op_valid,
    input  logic              stall,
    input  logic              blk_start,
    input  logic [LIST_W-1:0] blk_list,
    input  logic              blk_u,
    output logic [OP_W-1:0]   alu_operation,
    output logic              alu_op_valid,
    output logic              blk_busy,
    output logic [IDX_W-1:0]  blk_reg_idx,
    output logic              blk_last,
    output logic              blk_done,
    output logic [IDX_W:0]    blk_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state_q,     state_d;
    logic [LIST_W-1:0] remaining_q, remaining_d;
    logic              dir_q,       dir_d;
    logic [OP_W-1:0]   op_q,        op_d;
    logic              valid_q,     valid_d;
    logic              busy_q,      busy_d;
    logic [IDX_W-1:0]  idx_q,       idx_d;
    logic              last_q,      last_d;
    logic              done_q,      done_d;
    logic [IDX_W:0]    count_q,     count_d;

    logic [OP_W-1:0]   norm_op;
    logic [IDX_W-1:0]  low_idx;
    logic [IDX_W:0]    list_pop;
    logic [LIST_W-1:0] rem_minus_one;
    logic              one_left;

    // Normal-path operation select.
    always_comb begin
        unique case (alu_op_mux)
            2'b00:   norm_op = ir_op;
            2'b01:   norm_op = cs_op;
            2'b10:   norm_op = u ? OP_ADD : OP_SUB;
            default: norm_op = OP_MOV;
        endcase
    end

    // Index of the lowest register still pending (scan high to low so the lowest wins).
    always_comb begin
        low_idx = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (remaining_q[i]) low_idx = IDX_W'(i);
        end
    end

    // Number of registers in the incoming list, reported for base adjustment.
    always_comb begin
        list_pop = '0;
        for (int i = 0; i < LIST_W; i++) begin
            list_pop = list_pop + (IDX_W + 1)'(blk_list[i]);
        end
    end

    // x & (x-1) clears the lowest set bit; a zero result means one bit was left.
    always_comb begin
        rem_minus_one = remaining_q - LIST_W'(1);
        one_left      = (remaining_q & rem_minus_one) == '0;
    end

    // Next-state and next-output computation; a stall leaves every register as is.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        op_d        = op_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        idx_d       = idx_q;
        last_d      = last_q;
        done_d      = done_q;
        count_d     = count_q;

        if (!stall) begin
            unique case (state_q)
                ST_IDLE: begin
                    op_d    = norm_op;
                    valid_d = op_valid;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    last_d  = 1'b0;
                    done_d  = 1'b0;
                    if (blk_start) begin
                        remaining_d = blk_list;
                        dir_d       = blk_u;
                        count_d     = list_pop;
                        state_d     = (blk_list != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    op_d        = dir_q ? OP_ADD : OP_SUB;
                    valid_d     = 1'b1;
                    busy_d      = 1'b1;
                    idx_d       = low_idx;
                    last_d      = one_left;
                    done_d      = 1'b0;
                    remaining_d = remaining_q & rem_minus_one;
                    if (one_left) state_d = ST_DONE;
                end
                ST_DONE: begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            op_q        <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            op_q        <= op_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            done_q      <= done_d;
            count_q     <= count_d;
        end
    end

    assign alu_operation = op_q;
    assign alu_op_valid  = valid_q;
    assign blk_busy      = busy_q;
    assign blk_reg_idx   = idx_q;
    assign blk_last      = last_q;
    assign blk_done      = done_q;
    assign blk_count     = count_q;

endmodule
